mem_responder: RTL and testbench

Synthesizable multi-channel memory responder for the GPU data/program memory interfaces. It answers the valid/ready read and write requests the GPU memory controllers issue, and holds a configurable response latency per channel. Benches and FPGA builds use it in place of the behavioural memory class. Contents are preloaded through a host port while the GPU is idle.

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_channel.sv | 122 ++++++++++++
 rtl/mem_responder.sv | 80 ++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the multi-channel memory responder: channel FSM states,
// request kinds and the latency counter width.
package mem_responder_pkg;

  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write in IDLE, counts out the
// response latency in WAIT, then holds ready in RESP until valid drops.
module mem_responder_channel
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid_i,
  input  logic [ADDR_BITS-1:0] read_address_i,
  input  logic                 write_valid_i,
  input  logic [ADDR_BITS-1:0] write_address_i,
  input  logic [DATA_BITS-1:0] write_data_i,
  output logic                 read_ready_o,
  output logic                 write_ready_o,
  output logic                 commit_o,
  output logic [ADDR_BITS-1:0] commit_addr_o,
  output logic [DATA_BITS-1:0] commit_data_o,
  output logic                 sample_o,
  output logic [ADDR_BITS-1:0] sample_addr_o,
  output logic                 idle_o
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   read_ready_q, read_ready_d;
  logic                   write_ready_q, write_ready_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    read_ready_d  = read_ready_q;
    write_ready_d = write_ready_q;
    commit_o      = 1'b0;
    sample_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (read_valid_i) begin
          op_d    = OP_READ;
          addr_d  = read_address_i;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end else if (write_valid_i) begin
          op_d    = OP_WRITE;
          addr_d  = write_address_i;
          data_d  = write_data_i;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          // Storage side effects are suppressed on a reset edge so a pending
          // write is discarded rather than committed.
          if (op_q == OP_READ) begin
            sample_o     = !reset;
            read_ready_d = 1'b1;
          end else begin
            commit_o      = !reset;
            write_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      RESP: begin
        if ((op_q == OP_READ && !read_valid_i) || (op_q == OP_WRITE && !write_valid_i)) begin
          read_ready_d  = 1'b0;
          write_ready_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      read_ready_q  <= read_ready_d;
      write_ready_q <= write_ready_d;
    end
  end

  // Captured request fields are only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign read_ready_o  = read_ready_q;
  assign write_ready_o = write_ready_q;
  assign commit_addr_o = addr_q;
  assign commit_data_o = data_q;
  assign sample_addr_o = addr_q;
  assign idle_o        = (state_q == IDLE);

endmodule

// File: rtl/mem_responder.sv
// Multi-channel valid/ready memory responder: shared storage with host
// preload, per-channel latency FSMs, write arbitration and read muxing.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]                 read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]                 write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]                 write_ready,
  input  logic                                load_en,
  input  logic [ADDR_BITS-1:0]                load_addr,
  input  logic [DATA_BITS-1:0]                load_data,
  output logic                                idle
);

  logic [DATA_BITS-1:0]                mem_q [2**ADDR_BITS];
  logic [CHANNELS-1:0]                 commit, sample, ch_idle;
  logic [CHANNELS-1:0][ADDR_BITS-1:0]  commit_addr, sample_addr;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  commit_data;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mem_responder_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .read_valid_i    (read_valid[c]),
      .read_address_i  (read_address[c]),
      .write_valid_i   (write_valid[c]),
      .write_address_i (write_address[c]),
      .write_data_i    (write_data[c]),
      .read_ready_o    (read_ready[c]),
      .write_ready_o   (write_ready[c]),
      .commit_o        (commit[c]),
      .commit_addr_o   (commit_addr[c]),
      .commit_data_o   (commit_data[c]),
      .sample_o        (sample[c]),
      .sample_addr_o   (sample_addr[c]),
      .idle_o          (ch_idle[c])
    );
  end

  // NOTE: storage is deliberately not reset; preloaded contents survive a
  // reset and the array maps onto plain RAM. Later assignments override
  // earlier ones, so ascending channel order then host load gives the
  // highest channel, and above it the host, priority on an address clash.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (commit[c]) mem_q[commit_addr[c]] <= commit_data[c];
    end
    if (load_en) mem_q[load_addr] <= load_data;
  end

  // Reads see the pre-edge contents, i.e. old data on a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sample[c]) read_data_q[c] <= mem_q[sample_addr[c]];
      end
    end
  end

  assign read_data = read_data_q;
  assign idle      = &ch_idle;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// multi-channel traffic checked against an array-based storage model.
module tb_mem_responder;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int CH  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [CH-1:0]         rv, wv;
  logic [CH-1:0][AW-1:0] ra, wa;
  logic [CH-1:0][DW-1:0] wd;
  logic                  load_en;
  logic [AW-1:0]         load_addr;
  logic [DW-1:0]         load_data;

  logic [CH-1:0]         rr_a, wr_a, rr_b, wr_b;
  logic [CH-1:0][DW-1:0] rd_a, rd_b;
  logic                  idle_a, idle_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] model [2**AW];

  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_BITS(AW), .DATA_BITS(DW), .CHANNELS(CH), .LATENCY(LAT)) dut_a (
    .clk(clk), .reset(reset),
    .read_valid(rv), .read_address(ra), .read_ready(rr_a), .read_data(rd_a),
    .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr_a),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .idle(idle_a)
  );

  mem_responder #(.ADDR_BITS(AW), .DATA_BITS(DW), .CHANNELS(CH), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .read_valid(rv), .read_address(ra), .read_ready(rr_b), .read_data(rd_b),
    .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .idle(idle_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One transaction round on the channels in the masks: ready must appear
  // exactly LAT edges after acceptance, hold for 'hold' extra edges, and drop
  // on the edge valid is seen low. Reads expect the pre-transaction contents.
  task automatic issue(input string name, input logic [CH-1:0] rmask, input logic [CH-1:0] wmask,
                       input int hold, output int acc);
    logic [DW-1:0] exp_rd [CH];
    for (int c = 0; c < CH; c++) exp_rd[c] = model[ra[c]];
    rv = rmask;
    wv = wmask;
    tick();
    acc = cyc;
    check({name, ":busy"}, 32'(idle_a), 32'(0));
    for (int k = 0; k <= LAT; k++) begin
      if (k > 0) tick();
      check($sformatf("%s:rready_e%0d", name, k), 32'(rr_a), (k == LAT) ? 32'(rmask) : 32'(0));
      check($sformatf("%s:wready_e%0d", name, k), 32'(wr_a), (k == LAT) ? 32'(wmask) : 32'(0));
    end
    for (int c = 0; c < CH; c++) begin
      if (rmask[c]) begin
        check($sformatf("%s:rdata_a%0d", name, c), 32'(rd_a[c]), 32'(exp_rd[c]));
        check($sformatf("%s:rdata_b%0d", name, c), 32'(rd_b[c]), 32'(exp_rd[c]));
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (wmask[c]) model[wa[c]] = wd[c];
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, ":rhold"}, 32'(rr_a), 32'(rmask));
      check({name, ":whold"}, 32'(wr_a), 32'(wmask));
    end
    rv = '0;
    wv = '0;
    tick();
    check({name, ":rdrop"}, 32'(rr_a | rr_b), 32'(0));
    check({name, ":wdrop"}, 32'(wr_a | wr_b), 32'(0));
    check({name, ":idle"}, 32'({idle_a, idle_b}), 32'(2'b11));
    for (int c = 0; c < CH; c++) begin
      if (rmask[c]) check($sformatf("%s:rkeep%0d", name, c), 32'(rd_a[c]), 32'(exp_rd[c]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1;
    logic [CH-1:0] rm, wm;
    logic [DW-1:0] exp4 [CH];

    reset = 1'b1; rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    tick();
    tick();
    check("reset:rready", 32'(rr_a | rr_b), 32'(0));
    check("reset:wready", 32'(wr_a | wr_b), 32'(0));
    check("reset:rdata_a", 32'(rd_a), 32'(0));
    check("reset:idle", 32'({idle_a, idle_b}), 32'(2'b11));
    reset = 1'b0;

    // Host preload: 0..15 = 0x10+i, 16..31 random.
    for (int i = 0; i < 32; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = (i < 16) ? DW'(8'h10 + i) : DW'($urandom);
      model[i]  = load_data;
      tick();
    end
    load_en = 1'b0;

    ra[0] = 8'd5;
    issue("preload_rd5", 4'b0001, 4'b0000, 1, acc0);
    check("preload_rd5:value", 32'(rd_a[0]), 32'(8'h15));

    // Back-to-back write then read costs LAT+2 cycles.
    wa[1] = 8'd3; wd[1] = 8'hAA;
    issue("wr3", 4'b0000, 4'b0010, 0, acc0);
    ra[2] = 8'd3;
    issue("rd3", 4'b0100, 4'b0000, 0, acc1);
    check("rd3:value", 32'(rd_a[2]), 32'(8'hAA));
    check("turnaround", 32'(acc1 - acc0), 32'(LAT + 2));

    // Same-edge collision: ch3 wins, ch1 read sees old value.
    wa[0] = 8'd7; wd[0] = 8'h11;
    wa[3] = 8'd7; wd[3] = 8'h33;
    ra[1] = 8'd7;
    issue("collide", 4'b0010, 4'b1001, 0, acc0);
    check("collide:old", 32'(rd_a[1]), 32'(8'h17));
    ra[2] = 8'd7;
    issue("collide_rb", 4'b0100, 4'b0000, 0, acc0);
    check("collide:winner", 32'(rd_a[2]), 32'(8'h33));

    // Read has priority; the write stays pending until the channel idles.
    ra[0] = 8'd2; wa[0] = 8'd2; wd[0] = 8'h55;
    rv = 4'b0001; wv = 4'b0001;
    tick();
    tick();
    check("prio:r_early", 32'(rr_a), 32'(0));
    tick();
    check("prio:rready", 32'({rr_a, wr_a}), 32'({4'b0001, 4'b0000}));
    check("prio:rdata", 32'(rd_a[0]), 32'(model[2]));
    rv = 4'b0000;
    tick();
    check("prio:rdrop", 32'({rr_a, idle_a}), 32'({4'b0000, 1'b1}));
    tick();
    check("prio:w_accept", 32'(idle_a), 32'(0));
    tick();
    check("prio:w_early", 32'(wr_a), 32'(0));
    tick();
    check("prio:wready", 32'(wr_a), 32'(4'b0001));
    model[2] = 8'h55;
    wv = 4'b0000;
    tick();
    check("prio:wdrop", 32'({wr_a, idle_a}), 32'({4'b0000, 1'b1}));
    ra[3] = 8'd2;
    issue("prio_rb", 4'b1000, 4'b0000, 0, acc0);
    check("prio:new", 32'(rd_a[3]), 32'(8'h55));

    // Randomized multi-channel traffic against the storage model.
    for (int n = 0; n < 24; n++) begin
      rm = CH'($urandom);
      wm = CH'($urandom) & ~rm;
      if ((rm | wm) == '0) rm = 4'b0001;
      for (int c = 0; c < CH; c++) begin
        ra[c] = AW'($urandom_range(0, 31));
        wa[c] = AW'($urandom_range(0, 31));
        wd[c] = DW'($urandom);
      end
      issue($sformatf("rand%0d", n), rm, wm, $urandom_range(0, 2), acc0);
    end

    // All four channels with LATENCY=1 complete on the same edge.
    for (int c = 0; c < CH; c++) begin
      ra[c]   = AW'(c * 8 + $urandom_range(0, 7));
      exp4[c] = model[ra[c]];
    end
    rv = 4'b1111;
    tick();
    check("all4:accept", 32'({rr_b, idle_b}), 32'(0));
    tick();
    check("all4:rready_b", 32'(rr_b), 32'(4'b1111));
    for (int c = 0; c < CH; c++) check($sformatf("all4:rdata_b%0d", c), 32'(rd_b[c]), 32'(exp4[c]));
    tick();
    check("all4:rready_a", 32'(rr_a), 32'(4'b1111));
    rv = 4'b1000;
    tick();
    check("all4:partial", 32'({rr_b, idle_b, idle_a}), 32'({4'b1000, 2'b00}));
    rv = 4'b0000;
    tick();
    check("all4:done", 32'({rr_b, idle_b, idle_a}), 32'({4'b0000, 2'b11}));

    // Reset one edge after a write is accepted discards it.
    wa[2] = 8'd9; wd[2] = ~model[9];
    wv = 4'b0100;
    tick();
    reset = 1'b1;
    wv = 4'b0000;
    tick();
    check("rst:wready", 32'({wr_a, wr_b}), 32'(0));
    check("rst:idle", 32'({idle_a, idle_b}), 32'(2'b11));
    check("rst:rdata_a", 32'(rd_a), 32'(0));
    check("rst:rdata_b", 32'(rd_b), 32'(0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst:no_wready", 32'({wr_a, wr_b}), 32'(0));
    end
    ra[0] = 8'd9;
    issue("rst_rb", 4'b0001, 4'b0000, 0, acc0);
    check("rst:unchanged", 32'(rd_a[0]), 32'(model[9]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
